prbs_checker_lfsr: RTL and testbench

Receive-side PRBS checker paired with the PRBS generator path. It takes a 1-bit stream qualified by a per-bit strobe and self-synchronises an internal LFSR to that stream. Once locked, it compares every received bit against the locally predicted bit and reports lock status, per-bit error pulses, and saturating bit and error counters. It sits after the loopback/capture path and is read by the status register block.

---
 rtl/prbs_checker_lfsr.sv | 188 ++++++++++++++++++
 tb/tb_prbs_checker_lfsr.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker_lfsr.sv
// Receive-side PRBS checker: self-synchronising LFSR with lock tracking,
// per-bit error pulses and saturating bit/error counters.
module prbs_checker_lfsr #(
  parameter int LOCK_THRESH = 64,
  parameter int LOSS_WIN    = 128,
  parameter int LOSS_THRESH = 16
) (
  input  logic        dac_clk,
  input  logic        reset_n,
  input  logic        bit_valid,
  input  logic        rx_bit,
  input  logic [2:0]  pn_select,
  input  logic        clear_counters,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count,
  output logic [31:0] bit_count,
  output logic        err_saturated
);

  typedef enum logic {SEARCH, LOCKED} state_e;

  localparam logic [7:0]  LOCK_T   = 8'(LOCK_THRESH);
  localparam logic [9:0]  WIN_LAST = 10'(LOSS_WIN - 1);
  localparam logic [10:0] ERR_T    = 11'(LOSS_THRESH);

  state_e      state_q, state_d;
  logic [2:0]  pn_q, pn_d;
  logic [30:0] hist_q, hist_d;
  logic [4:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d;
  logic [9:0]  win_cnt_q, win_cnt_d;
  logic [10:0] win_err_q, win_err_d;
  logic        pulse_q, pulse_d;
  logic [31:0] ec_q, ec_d;
  logic [31:0] bc_q, bc_d;
  logic        sat_q, sat_d;

  logic [4:0]  n_len;
  logic [30:0] mask;
  logic        tap_n, tap_t;
  logic        exp_bit;
  logic        can_cmp;

  // Tap selection and prediction for the registered polynomial
  always_comb begin
    n_len = 5'd7;
    mask  = 31'h0000_007F;
    tap_n = hist_q[6];
    tap_t = hist_q[5];
    case (pn_q)
      3'd1: begin
        n_len = 5'd9;
        mask  = 31'h0000_01FF;
        tap_n = hist_q[8];
        tap_t = hist_q[4];
      end
      3'd2: begin
        n_len = 5'd11;
        mask  = 31'h0000_07FF;
        tap_n = hist_q[10];
        tap_t = hist_q[8];
      end
      3'd3: begin
        n_len = 5'd15;
        mask  = 31'h0000_7FFF;
        tap_n = hist_q[14];
        tap_t = hist_q[13];
      end
      3'd4: begin
        n_len = 5'd23;
        mask  = 31'h007F_FFFF;
        tap_n = hist_q[22];
        tap_t = hist_q[17];
      end
      3'd5: begin
        n_len = 5'd31;
        mask  = 31'h7FFF_FFFF;
        tap_n = hist_q[30];
        tap_t = hist_q[27];
      end
      default: ;
    endcase
    exp_bit = tap_n ^ tap_t;
    can_cmp = (fill_q >= n_len) && (|(hist_q & mask));
  end

  // Next-state: search/lock FSM, history, window and counters
  always_comb begin
    state_d   = state_q;
    pn_d      = pn_select;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    pulse_d   = 1'b0;
    ec_d      = ec_q;
    bc_d      = bc_q;
    if (pn_select != pn_q) begin
      state_d   = SEARCH;
      hist_d    = '0;
      fill_d    = '0;
      match_d   = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        SEARCH: begin
          hist_d = {hist_q[29:0], rx_bit};
          if (fill_q != 5'd31) fill_d = fill_q + 5'd1;
          if (can_cmp && (rx_bit == exp_bit)) begin
            match_d = match_q + 8'd1;
            if (match_d == LOCK_T) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          hist_d = {hist_q[29:0], exp_bit};
          if (~&bc_q) bc_d = bc_q + 32'd1;
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 10'd1;
          end
          if (rx_bit != exp_bit) begin
            pulse_d = 1'b1;
            if (~&ec_q) ec_d = ec_q + 32'd1;
            if ((win_err_q + 11'd1) >= ERR_T) begin
              state_d   = SEARCH;
              fill_d    = '0;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else if (win_cnt_q != WIN_LAST) begin
              win_err_d = win_err_q + 11'd1;
            end
          end
        end
        default: ;
      endcase
    end
    sat_d = sat_q | (&ec_d);
    if (clear_counters) begin
      ec_d  = '0;
      bc_d  = '0;
      sat_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      pn_q      <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      pulse_q   <= 1'b0;
      ec_q      <= '0;
      bc_q      <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pn_q      <= pn_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      pulse_q   <= pulse_d;
      ec_q      <= ec_d;
      bc_q      <= bc_d;
      sat_q     <= sat_d;
    end
  end

  assign locked        = (state_q == LOCKED);
  assign err_pulse     = pulse_q;
  assign err_count     = ec_q;
  assign bit_count     = bc_q;
  assign err_saturated = sat_q;

endmodule

// File: tb/tb_prbs_checker_lfsr.sv
// Randomised bench for prbs_checker_lfsr with a queue-style
// behavioural reference of the lock/loss rules.
module tb_prbs_checker_lfsr;

  localparam int LOCK_THRESH = 64;
  localparam int LOSS_WIN    = 128;
  localparam int LOSS_THRESH = 16;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  logic        dac_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        bit_valid = 1'b0;
  logic        rx_bit = 1'b0;
  logic [2:0]  pn_select = 3'd0;
  logic        clear_counters = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;
  logic        err_saturated;

  int errors = 0;
  int checks = 0;

  prbs_checker_lfsr #(
    .LOCK_THRESH(LOCK_THRESH),
    .LOSS_WIN(LOSS_WIN),
    .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .dac_clk(dac_clk),
    .reset_n(reset_n),
    .bit_valid(bit_valid),
    .rx_bit(rx_bit),
    .pn_select(pn_select),
    .clear_counters(clear_counters),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count),
    .err_saturated(err_saturated)
  );

  always #5 dac_clk = ~dac_clk;

  // reference model state
  logic        m_locked, m_pulse, m_sat;
  logic [31:0] m_ec, m_bc;
  logic [2:0]  m_pn;
  int          m_fill, m_match, m_wc, m_we;
  logic        mh[31];

  // stream generator state
  logic        gq[31];
  int          g_n, g_t, g_cnt;

  function automatic int pn_n(input logic [2:0] s);
    case (s)
      3'd1: return 9;
      3'd2: return 11;
      3'd3: return 15;
      3'd4: return 23;
      3'd5: return 31;
      default: return 7;
    endcase
  endfunction

  function automatic int pn_t(input logic [2:0] s);
    case (s)
      3'd1: return 5;
      3'd2: return 9;
      3'd3: return 14;
      3'd4: return 18;
      3'd5: return 28;
      default: return 6;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == MAX) ? x : x + 32'd1;
  endfunction

  function automatic void m_reset();
    m_locked = 0; m_pulse = 0; m_sat = 0;
    m_ec = 0; m_bc = 0; m_pn = 0;
    m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
    foreach (mh[i]) mh[i] = 1'b0;
  endfunction

  function automatic void m_push(input logic b);
    for (int i = 30; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = b;
  endfunction

  function automatic void model_step(input logic v, input logic b,
                                     input logic clr);
    int n, t;
    logic e, nz;
    m_pulse = 0;
    if (pn_select != m_pn) begin
      m_pn = pn_select;
      m_locked = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
      foreach (mh[i]) mh[i] = 1'b0;
    end else if (v) begin
      n = pn_n(m_pn);
      t = pn_t(m_pn);
      e = mh[n-1] ^ mh[t-1];
      if (!m_locked) begin
        nz = 0;
        for (int i = 0; i < n; i++) nz = nz | mh[i];
        if (m_fill >= n && nz && b == e) begin
          m_match++;
          if (m_match == LOCK_THRESH) m_locked = 1;
        end else begin
          m_match = 0;
        end
        m_push(b);
        m_fill = (m_fill < 31) ? m_fill + 1 : 31;
      end else begin
        m_bc = sat_inc(m_bc);
        m_wc++;
        if (b != e) begin
          m_pulse = 1;
          m_ec = sat_inc(m_ec);
          m_we++;
          if (m_we >= LOSS_THRESH) begin
            m_locked = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
          end
        end
        if (m_wc == LOSS_WIN) begin
          m_wc = 0; m_we = 0;
        end
        m_push(e);
      end
    end
    if (m_ec == MAX) m_sat = 1;
    if (clr) begin
      m_ec = 0; m_bc = 0; m_sat = 0;
    end
  endfunction

  task automatic gen_init(input logic [2:0] s);
    g_n = pn_n(s);
    g_t = pn_t(s);
    g_cnt = 0;
    foreach (gq[i]) gq[i] = 1'b0;
  endtask

  function automatic logic gen_bit();
    logic b;
    if (g_cnt < g_n) b = (g_cnt == 0) ? 1'b1 : 1'($urandom_range(1, 0));
    else b = gq[g_n-1] ^ gq[g_t-1];
    for (int i = 30; i > 0; i--) gq[i] = gq[i-1];
    gq[0] = b;
    g_cnt++;
    return b;
  endfunction

  task automatic cyc(input logic v, input logic b, input logic clr);
    @(negedge dac_clk);
    bit_valid = v;
    rx_bit = b;
    clear_counters = clr;
    @(posedge dac_clk);
    model_step(v, b, clr);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    m_reset();
    repeat (3) @(posedge dac_clk);
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL rst_locked got %b want 0", locked);
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_pulse got %b want 0", err_pulse);
    end
    checks++;
    if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_cnt got e=%h b=%h want 0", err_count, bit_count);
    end
    checks++;
    if (err_saturated !== 1'b0) begin
      errors++; $display("FAIL rst_sat got %b want 0", err_saturated);
    end
    @(negedge dac_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_pn7_lock();
    int lk;
    lk = 0;
    gen_init(3'd0);
    for (int i = 1; i <= 200 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      checks++;
      if (locked !== m_locked || err_pulse !== m_pulse) begin
        errors++;
        $display("FAIL pn7_cyc got l=%b p=%b want l=%b p=%b",
                 locked, err_pulse, m_locked, m_pulse);
      end
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 71) begin
      errors++; $display("FAIL pn7_lock_bit got %0d want 71", lk);
    end
    for (int i = 0; i < 1000; i++) cyc(1'b1, gen_bit(), 1'b0);
    checks++;
    if (bit_count !== 32'd1000 || err_count !== 32'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pn7_counts got b=%0d e=%0d l=%b want 1000 0 1",
               bit_count, err_count, locked);
    end
  endtask

  task automatic test_single_err_pn31();
    int lk, np;
    pn_select = 3'd5;
    cyc(1'b0, 1'b0, 1'b1);
    gen_init(3'd5);
    lk = 0;
    for (int i = 1; i <= 300 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 95) begin
      errors++; $display("FAIL pn31_lock_bit got %0d want 95", lk);
    end
    cyc(1'b1, ~gen_bit(), 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 32'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pn31_flip got p=%b e=%0d l=%b want 1 1 1",
               err_pulse, err_count, locked);
    end
    np = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (err_pulse === 1'b1) np++;
    end
    checks++;
    if (np != 0 || err_count !== 32'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pn31_nomult got pulses=%0d e=%0d l=%b want 0 1 1",
               np, err_count, locked);
    end
  endtask

  task automatic test_loss_relock_pn15();
    int lk, ne;
    pn_select = 3'd3;
    cyc(1'b0, 1'b0, 1'b1);
    gen_init(3'd3);
    lk = 0;
    for (int i = 1; i <= 200 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 79) begin
      errors++; $display("FAIL pn15_lock_bit got %0d want 79", lk);
    end
    ne = 0;
    for (int i = 0; i < 80 && ne < 16; i++) begin
      if (i % 5 == 0) begin
        cyc(1'b1, ~gen_bit(), 1'b0);
        ne++;
      end else begin
        cyc(1'b1, gen_bit(), 1'b0);
      end
      checks++;
      if (locked !== m_locked || err_pulse !== m_pulse ||
          err_count !== m_ec || bit_count !== m_bc) begin
        errors++;
        $display("FAIL pn15_cyc got l=%b p=%b e=%0d b=%0d want %b %b %0d %0d",
                 locked, err_pulse, err_count, bit_count,
                 m_locked, m_pulse, m_ec, m_bc);
      end
    end
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b1 || err_count !== 32'd16) begin
      errors++;
      $display("FAIL pn15_loss got l=%b p=%b e=%0d want 0 1 16",
               locked, err_pulse, err_count);
    end
    lk = 0;
    for (int i = 1; i <= 200 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 79 || err_count !== 32'd16 || bit_count !== 32'd76) begin
      errors++;
      $display("FAIL pn15_relock got bits=%0d e=%0d b=%0d want 79 16 76",
               lk, err_count, bit_count);
    end
  endtask

  task automatic test_zero_pn9();
    pn_select = 3'd1;
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0 || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL zero_cyc got l=%b p=%b want 0 0", locked, err_pulse);
      end
    end
    checks++;
    if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++;
      $display("FAIL zero_cnt got e=%0d b=%0d want 0 0", err_count, bit_count);
    end
  endtask

  task automatic test_clear_pn_change();
    int lk;
    pn_select = 3'd4;
    cyc(1'b0, 1'b0, 1'b1);
    gen_init(3'd4);
    lk = 0;
    for (int i = 1; i <= 200 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 87) begin
      errors++; $display("FAIL pn23_lock_bit got %0d want 87", lk);
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) cyc(1'b1, ~gen_bit(), 1'b0);
      else cyc(1'b1, gen_bit(), 1'b0);
    end
    checks++;
    if (err_count !== 32'd5 || bit_count !== 32'd20) begin
      errors++;
      $display("FAIL pn23_pre got e=%0d b=%0d want 5 20", err_count, bit_count);
    end
    cyc(1'b1, ~gen_bit(), 1'b1);
    checks++;
    if (err_count !== 32'd0 || bit_count !== 32'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_prio got e=%0d b=%0d l=%b want 0 0 1",
               err_count, bit_count, locked);
    end
    pn_select = 3'd2;
    cyc(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL pnchg_unlock got %b want 0", locked);
    end
    gen_init(3'd2);
    lk = 0;
    for (int i = 1; i <= 200 && lk == 0; i++) begin
      cyc(1'b1, gen_bit(), 1'b0);
      if (locked === 1'b1) lk = i;
    end
    checks++;
    if (lk != 75) begin
      errors++; $display("FAIL pn11_lock_bit got %0d want 75", lk);
    end
  endtask

  task automatic test_random();
    logic [2:0] s;
    logic v, b, c;
    int rate;
    for (int r = 0; r < 4; r++) begin
      s = 3'($urandom_range(7, 0));
      rate = (r == 2) ? 6 : 64;
      pn_select = s;
      cyc(1'b0, 1'b0, 1'b0);
      gen_init(s);
      for (int i = 0; i < 800; i++) begin
        v = ($urandom_range(3, 0) != 0);
        b = v ? gen_bit() : 1'($urandom_range(1, 0));
        if (v && $urandom_range(rate - 1, 0) == 0) b = ~b;
        c = ($urandom_range(199, 0) == 0);
        cyc(v, b, c);
        checks++;
        if ({locked, err_pulse, err_saturated, err_count, bit_count} !==
            {m_locked, m_pulse, m_sat, m_ec, m_bc}) begin
          errors++;
          $display("FAIL rand_cyc pn=%0d got l=%b p=%b s=%b e=%0d b=%0d want %b %b %b %0d %0d",
                   s, locked, err_pulse, err_saturated, err_count, bit_count,
                   m_locked, m_pulse, m_sat, m_ec, m_bc);
        end
      end
    end
  endtask

  task automatic test_saturation();
    pn_select = 3'd0;
    cyc(1'b0, 1'b0, 1'b0);
    gen_init(3'd0);
    for (int i = 0; i < 300 && !m_locked; i++) cyc(1'b1, gen_bit(), 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL sat_lock got %b want 1", locked);
    end
    force dut.ec_q = 32'hFFFF_FFFD;
    force dut.bc_q = 32'hFFFF_FFFE;
    #1;
    release dut.ec_q;
    release dut.bc_q;
    m_ec = 32'hFFFF_FFFD;
    m_bc = 32'hFFFF_FFFE;
    cyc(1'b1, ~gen_bit(), 1'b0);
    checks++;
    if (err_count !== 32'hFFFF_FFFE || err_saturated !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre got e=%h s=%b want fffffffe 0",
               err_count, err_saturated);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, ~gen_bit(), 1'b0);
    checks++;
    if (err_count !== MAX || err_saturated !== 1'b1 ||
        bit_count !== MAX || locked !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got e=%h b=%h s=%b l=%b want ffffffff ffffffff 1 1",
               err_count, bit_count, err_saturated, locked);
    end
    cyc(1'b1, gen_bit(), 1'b0);
    @(negedge dac_clk);
    bit_valid = 1'b1;
    rx_bit = gen_bit();
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({locked, err_pulse, err_saturated, err_count, bit_count} !== 67'd0) begin
      errors++;
      $display("FAIL async_rst got l=%b p=%b s=%b e=%h b=%h want all 0",
               locked, err_pulse, err_saturated, err_count, bit_count);
    end
    bit_valid = 1'b0;
    @(negedge dac_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_pn7_lock();
    test_single_err_pn31();
    test_loss_relock_pn15();
    test_zero_pn9();
    test_clear_pn_change();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
